// File: rtl/dram2videoaxis_pkg.sv
// Shared definitions for the frame-buffer reader: request word fields,
// stored pixel word layout and request FSM encoding.
package dram2videoaxis_pkg;

    localparam int CTRL_W   = 40;
    localparam int LEN_MSB  = 39;
    localparam int LEN_LSB  = 32;
    localparam int ADDR_MSB = 31;
    localparam int ADDR_LSB = 0;

    localparam int RGB_MSB = 31;
    localparam int RGB_LSB = 8;
    localparam logic [7:0] PIX_PAD = 8'hff;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/dram2videoaxis_pixel_fifo.sv
// First-word-fall-through FIFO with a registered output stage; the output
// register counts toward occupancy so the credit logic sees every stored word.
module pixel_fifo #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 24,
    localparam int AW = $clog2(DEPTH),
    localparam int OW = AW + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [OW-1:0]    occupancy
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      mem_cnt;
    logic             refill, pop_mem, bypass, wr_mem;

    // Output stage takes a new word when empty or being consumed; an empty
    // array lets an incoming word go straight to the output register.
    assign refill  = !rd_valid || rd_en;
    assign pop_mem = refill && (mem_cnt != '0);
    assign bypass  = refill && (mem_cnt == '0) && wr_en;
    assign wr_mem  = wr_en && !bypass;

    assign occupancy = OW'(mem_cnt) + OW'(rd_valid);

    always_ff @(posedge clk) begin
        if (wr_mem)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_mem)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_mem) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end else if (bypass) begin
                rd_data <= wr_data;
            end
            if (refill)
                rd_valid <= pop_mem || bypass;
            case ({wr_mem, pop_mem})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

endmodule

// File: rtl/dram2videoaxis.sv
// Frame-buffer reader: issues credit-limited DRAM read bursts for a linear
// frame and replays the returned pixels as an AXI4-Stream video master.
module dram2videoaxis
    import dram2videoaxis_pkg::*;
#(
    parameter int          WIDTH      = 1600,
    parameter int          HEIGHT     = 900,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          BURST      = 64,
    parameter int          FIFO_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [39:0] rd_ctrl_out,
    output logic        rd_ctrl_we,
    input  logic        rd_ctrl_ready,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    input  logic        play_sig,
    output logic        play_rtn,
    output logic        underrun
);

    localparam logic [31:0] FRAME_WORDS = 32'(WIDTH * HEIGHT);
    localparam int OW = $clog2(FIFO_DEPTH) + 2;
    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);

    state_t          state, state_nxt;
    logic [31:0]     remaining, word_idx, rem_eff, word_eff, used;
    logic [OW-1:0]   inflight, occ;
    logic [7:0]      cur_len, len_eff;
    logic            accept, push, fire, last_fire, load_frame, raise;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [7:0]      unused_pad;

    assign unused_pad = rd_data[7:0];
    assign cur_len    = rd_ctrl_out[LEN_MSB:LEN_LSB];
    assign accept     = rd_ctrl_we && rd_ctrl_ready;
    // Words with no reservation behind them are leftovers from before a reset.
    assign push       = rd_data_valid && (inflight != '0);
    assign fire       = m_axis_tvalid && m_axis_tready;
    assign last_fire  = fire && (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));

    // Look past a request being accepted this cycle so the next one can be
    // raised immediately; credit is reserved at raise time.
    always_comb begin
        rem_eff  = accept ? remaining - 32'(cur_len) : remaining;
        word_eff = accept ? word_idx + 32'(cur_len) : word_idx;
        len_eff  = (rem_eff >= 32'(BURST)) ? 8'(BURST) : rem_eff[7:0];
        used     = 32'(occ) + 32'(inflight);
        raise    = (state == ST_ISSUE) && (!rd_ctrl_we || accept) &&
                   (rem_eff != 32'd0) &&
                   (used + 32'(len_eff) <= 32'(FIFO_DEPTH));
    end

    always_comb begin
        state_nxt  = state;
        load_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                if (play_sig) begin
                    state_nxt  = ST_ISSUE;
                    load_frame = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (accept && rem_eff == 32'd0)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_fire) begin
                    if (play_sig) begin
                        state_nxt  = ST_ISSUE;
                        load_frame = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining   <= '0;
            word_idx    <= '0;
            rd_ctrl_we  <= 1'b0;
            rd_ctrl_out <= '0;
            inflight    <= '0;
        end else begin
            if (load_frame) begin
                remaining <= FRAME_WORDS;
                word_idx  <= '0;
            end else if (accept) begin
                remaining <= rem_eff;
                word_idx  <= word_eff;
            end
            if (raise) begin
                rd_ctrl_we  <= 1'b1;
                rd_ctrl_out <= {len_eff, BASE_ADDR + (word_eff << 2)};
            end else if (accept) begin
                rd_ctrl_we <= 1'b0;
            end
            inflight <= inflight + (raise ? OW'(len_eff) : OW'(0)) - (push ? OW'(1) : OW'(0));
        end
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (push),
        .wr_data   (rd_data[RGB_MSB:RGB_LSB]),
        .rd_en     (m_axis_tready),
        .rd_data   (m_axis_tdata),
        .rd_valid  (m_axis_tvalid),
        .occupancy (occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (fire) begin
            if (x == XW'(WIDTH - 1)) begin
                x <= '0;
                y <= (y == YW'(HEIGHT - 1)) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign play_rtn     = (state != ST_IDLE);
    assign m_axis_tuser = m_axis_tvalid && (x == '0) && (y == '0);
    assign m_axis_tlast = m_axis_tvalid && (x == XW'(WIDTH - 1));
    assign underrun     = play_rtn && !m_axis_tvalid && m_axis_tready;

endmodule

// File: tb/tb_dram2videoaxis.sv
// Bench for dram2videoaxis: random DRAM latency/ready model, expected request
// list and pixel stream derived from the frame layout, plus corner sequences.
module tb_dram2videoaxis;
    import dram2videoaxis_pkg::*;

    localparam int W  = 6;
    localparam int H  = 5;
    localparam int B  = 8;
    localparam int FD = 16;
    localparam int N  = W * H;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk, rst_n;
    logic [39:0] rd_ctrl_out;
    logic        rd_ctrl_we, rd_ctrl_ready;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
    logic        play_sig, play_rtn, underrun;

    dram2videoaxis #(
        .WIDTH(W), .HEIGHT(H), .BASE_ADDR(BASE), .BURST(B), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_ctrl_out(rd_ctrl_out), .rd_ctrl_we(rd_ctrl_we), .rd_ctrl_ready(rd_ctrl_ready),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .play_sig(play_sig), .play_rtn(play_rtn), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lat; int rdy_pct; int req_pct; int nframes;
        int exp_pix; int exp_req; int min_und;
    } vec_t;

    typedef struct { int t; logic [31:0] w; } dword_t;

    vec_t   vecs[5];
    dword_t dq[$];

    int tests, fails, cyc;
    int lat, rdy_pct, req_pct, hold, hold_at, drop_at, dram_last;
    int req_word, reqs, pix_idx, pixels_out, outstanding, max_out, underruns;
    int first_we_cyc, first_tv_cyc, first_dv_cyc, play_cyc, guard;
    logic        p_tv, p_tr, p_we, p_rr;
    logic [25:0] p_dat;
    logic [39:0] p_out;

    function automatic logic [23:0] pix(input int i);
        return 24'(i * 40503 + 32'h13579b) ^ 24'(i << 9);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        int len, t;
        @(negedge clk);
        cyc++;
        if (p_tv && !p_tr) begin
            chk("axis_hold_valid", 64'(m_axis_tvalid), 64'(1));
            chk("axis_hold_data", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'(p_dat));
        end
        if (p_we && !p_rr)
            chk("req_hold", 64'({rd_ctrl_we, rd_ctrl_out}), 64'({1'b1, p_out}));
        if (rd_ctrl_we && first_we_cyc < 0) first_we_cyc = cyc;
        if (m_axis_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;

        rd_ctrl_ready = ($urandom_range(99) < req_pct);
        if (rd_ctrl_we && rd_ctrl_ready) begin
            len = (N - req_word < B) ? N - req_word : B;
            chk("req_addr", 64'(rd_ctrl_out[31:0]), 64'(BASE + 32'(req_word * 4)));
            chk("req_len", 64'(rd_ctrl_out[39:32]), 64'(len));
            for (int k = 0; k < len; k++) begin
                t = (cyc + lat > dram_last + 1) ? cyc + lat : dram_last + 1;
                dq.push_back('{t, {pix(req_word + k), PIX_PAD}});
                dram_last = t;
            end
            outstanding += len;
            if (outstanding > max_out) max_out = outstanding;
            chk("credit_bound", 64'(outstanding <= FD), 64'(1));
            req_word = (req_word + len) % N;
            reqs++;
        end

        if (dq.size() > 0 && dq[0].t <= cyc) begin
            rd_data_valid = 1'b1;
            rd_data = dq[0].w;
            dq.pop_front();
            if (first_dv_cyc < 0) first_dv_cyc = cyc;
        end else begin
            rd_data_valid = 1'b0;
            rd_data = $urandom;
        end

        if (hold_at >= 0 && pixels_out >= hold_at) begin
            hold = 200;
            hold_at = -1;
        end
        if (hold > 0) begin
            m_axis_tready = 1'b0;
            hold--;
        end else begin
            m_axis_tready = ($urandom_range(99) < rdy_pct);
        end
        #1;
        chk("underrun", 64'(underrun), 64'(play_rtn && !m_axis_tvalid && m_axis_tready));
        if (underrun) underruns++;
        if (m_axis_tvalid && m_axis_tready) begin
            chk("pix_data", 64'(m_axis_tdata), 64'(pix(pix_idx)));
            chk("pix_user", 64'(m_axis_tuser), 64'(pix_idx == 0));
            chk("pix_last", 64'(m_axis_tlast), 64'((pix_idx % W) == W - 1));
            pix_idx = (pix_idx + 1) % N;
            pixels_out++;
            outstanding--;
        end
        if (drop_at >= 0 && pixels_out >= drop_at) play_sig = 1'b0;

        p_tv = m_axis_tvalid; p_tr = m_axis_tready;
        p_dat = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        p_we = rd_ctrl_we; p_rr = rd_ctrl_ready; p_out = rd_ctrl_out;
    endtask

    task automatic run_play(input int nframes, input int exp_pix, input int exp_req,
                            input int min_und, input int hold_pix);
        pixels_out = 0; reqs = 0; underruns = 0; max_out = 0;
        first_we_cyc = -1; first_tv_cyc = -1; first_dv_cyc = -1;
        drop_at = (nframes - 1) * N + 10;
        hold_at = hold_pix;
        play_sig = 1'b1;
        play_cyc = cyc;
        guard = 0;
        do begin
            step();
            guard++;
        end while (play_rtn && guard < 20000);
        chk("frame_timeout", 64'(guard >= 20000), 64'(0));
        repeat (40) step();
        chk("pixels_out", 64'(pixels_out), 64'(exp_pix));
        chk("req_count", 64'(reqs), 64'(exp_req));
        chk("play_rtn_low", 64'(play_rtn), 64'(0));
        chk("underrun_seen", 64'(underruns >= min_und), 64'(1));
        chk("max_outstanding", 64'(max_out <= FD), 64'(1));
        chk("req_latency", 64'(first_we_cyc - play_cyc), 64'(2));
        chk("fwft_latency", 64'(first_tv_cyc - first_dv_cyc), 64'(1));
        drop_at = -1;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        lat = 5; rdy_pct = 100; req_pct = 100; hold = 0; hold_at = -1; drop_at = -1;
        dram_last = 0; req_word = 0; reqs = 0; pix_idx = 0; pixels_out = 0;
        outstanding = 0; max_out = 0; underruns = 0;
        p_tv = 0; p_tr = 0; p_we = 0; p_rr = 0; p_dat = '0; p_out = '0;
        rst_n = 1'b0; play_sig = 1'b0; rd_ctrl_ready = 1'b0;
        rd_data = '0; rd_data_valid = 1'b0; m_axis_tready = 1'b1;

        vecs[0] = '{5,   100, 100, 1, 30, 4,  1};
        vecs[1] = '{5,   60,  50,  2, 60, 8,  0};
        vecs[2] = '{1,   30,  100, 1, 30, 4,  0};
        vecs[3] = '{50,  100, 100, 1, 30, 4,  1};
        vecs[4] = '{12,  80,  70,  3, 90, 12, 0};

        #1;
        chk("rst_ctrl_out", 64'(rd_ctrl_out), 64'(0));
        chk("rst_ctrl_we", 64'(rd_ctrl_we), 64'(0));
        chk("rst_axis", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast}), 64'(0));
        chk("rst_play_rtn", 64'({play_rtn, underrun}), 64'(0));
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        for (int v = 0; v < 5; v++) begin
            lat = vecs[v].lat; rdy_pct = vecs[v].rdy_pct; req_pct = vecs[v].req_pct;
            run_play(vecs[v].nframes, vecs[v].exp_pix, vecs[v].exp_req, vecs[v].min_und, -1);
        end

        // Long downstream stall mid-frame with a shallow FIFO.
        lat = 3; rdy_pct = 100; req_pct = 100;
        run_play(1, 30, 4, 0, 12);

        // Reset while bursts are in flight.
        lat = 5; drop_at = -1; play_sig = 1'b1; guard = 0;
        pixels_out = 0;
        do begin
            step();
            guard++;
        end while (pixels_out < 3 && guard < 2000);
        chk("pre_reset_timeout", 64'(guard >= 2000), 64'(0));
        rst_n = 1'b0;
        play_sig = 1'b0;
        #1;
        chk("mid_rst_ctrl", 64'({rd_ctrl_we, rd_ctrl_out}), 64'(0));
        chk("mid_rst_axis", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast}), 64'(0));
        chk("mid_rst_play", 64'({play_rtn, underrun}), 64'(0));
        dq.delete();
        outstanding = 0; req_word = 0; pix_idx = 0;
        p_tv = 0; p_we = 0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        run_play(1, 30, 4, 1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dram2videoaxis.md
# dram2videoaxis

Frame-buffer reader: fetches a stored frame from DRAM in bursts and replays it as an AXI4-Stream video master (24-bit RGB, tuser = start-of-frame, tlast = end-of-line). It is the read-side counterpart of the video capture writer. It uses the same linear layout, word = {rgb[23:0], 8'hff} at byte address BASE_ADDR + (y*WIDTH + x)*4. It sits between the DRAM read port and the display/output video pipeline in a single clock domain.

## Interface
- WIDTH, 1600: active pixels per line.
- HEIGHT, 900: lines per frame.
- BASE_ADDR, 32'h0: byte address of pixel (0,0).
- BURST, 64: maximum words per read request; power of two, ≤ 255.
- FIFO_DEPTH, 256: pixel FIFO words; power of two, ≥ 2*BURST.
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- rd_ctrl_out  out  40  read request: len[39:32], byte addr[31:0].
- rd_ctrl_we  out  1  request valid; held until accepted.
- rd_ctrl_ready  in  1  DRAM reader accepts the request when rd_ctrl_we && rd_ctrl_ready.
- rd_data  in  32  returned word, in request order.
- rd_data_valid  in  1  one word per cycle when high; cannot be back-pressured.
- m_axis_tdata  out  24  pixel = word[31:8].
- m_axis_tvalid  out  1  pixel valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  high on pixel (0,0) only.
- m_axis_tlast  out  1  high on pixel x = WIDTH-1.
- play_sig  in  1  level request to play frames.
- play_rtn  out  1  high while a frame is being played.
- underrun  out  1  one-cycle pulse when FIFO is empty mid-frame while tready is high.

## Operation
- Reset values: rd_ctrl_out = 0, rd_ctrl_we = 0, m_axis_tvalid/tuser/tlast = 0, play_rtn = 0, underrun = 0, FIFO empty, all counters 0.
- The request FSM has the following states:
  - IDLE: if play_sig = 1, go to ISSUE; set play_rtn = 1, remaining = WIDTH*HEIGHT, word address = 0.
  - ISSUE: len = min(BURST, remaining). Drive the request when free credit ≥ len, where free credit = FIFO_DEPTH − (occupancy + in-flight words). On acceptance:
    - in-flight += len, address += len*4, remaining −= len;
    - if remaining becomes 0, go to DRAIN.
  - DRAIN: wait until the last pixel of the frame handshakes. Then:
    - if play_sig = 1, go to ISSUE with a fresh frame (play_rtn stays 1);
    - otherwise go to IDLE and set play_rtn = 0.
- While rd_ctrl_we = 1, rd_ctrl_out is stable and credit has already been reserved.
- Deasserting play_sig mid-frame does not abort; the current frame completes.
- Data path:
  - rd_data_valid pushes into the FIFO and decrements in-flight.
  - Overflow is impossible by credit; the bench asserts this.
- Output counters:
  - x increments on each tvalid && tready; at WIDTH-1 it wraps to 0 and y increments; at the end of the last line y wraps to 0.
  - tuser = (x == 0 && y == 0); tlast = (x == WIDTH-1).
- Simultaneous FIFO push and pop in the same cycle leaves occupancy unchanged.
- Arithmetic:
  - Remaining/word counters are 32-bit.
  - Byte address is BASE_ADDR + word_index*4, 32-bit wrap.
  - len is 8-bit; BURST = 256 is not allowed.

## Timing
- Request: rd_ctrl_we rises 1 cycle after entry to ISSUE with sufficient credit. Back-to-back accepted requests are possible on consecutive cycles.
- Read data appears on m_axis_tvalid 1 cycle after rd_data_valid (registered FIFO output, FWFT).
- AXI-S rules:
  - Once tvalid is high, tdata/tuser/tlast are stable until tready.
  - tvalid is deasserted only after a handshake.
- Underrun: tvalid = 0 while play_rtn = 1 and the frame is incomplete. underrun pulses on each such cycle with tready = 1.
- Asynchronous reset mid-burst: outputs clear immediately. Words still arriving after reset are discarded until the FSM issues again; the DRAM side must be reset together.

## Structure
- A shared package holds: ctrl field positions (LEN_MSB = 39, LEN_LSB = 32, ADDR 31:0), the pixel word format (RGB at [31:8], pad 8'hff), and FSM state encoding.
- Sub-module: pixel_fifo, a synchronous FWFT FIFO parameterized by depth/width with an occupancy output. The top holds the FSM, credit logic and x/y counters.

## Test plan
- WIDTH = 8, HEIGHT = 4, BURST = 4, tready = 1, DRAM model latency 5: one frame of 32 pixels → requests at addr 0x0,0x10,…,0x70, len 4; tuser only on pixel 0; tlast on every 8th pixel.
- WIDTH*HEIGHT = 30, BURST = 8 → last request len = 6 at addr 0x60; no further requests.
- tready held low for 200 cycles mid-frame with FIFO_DEPTH = 16 → outstanding words never exceed 16; no data lost; pixel order preserved.
- play_sig dropped at pixel 10 of a 32-pixel frame → all 32 pixels are output, then play_rtn = 0 and no new request.
- play_sig held high → the second frame starts with address 0x0 and tuser on its first pixel, with no gap beyond credit limits.
- DRAM latency 50 cycles → underrun pulses while tready = 1 and the FIFO is empty. rst_n asserted mid-burst → all outputs are 0 in the same cycle.
